// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: applies every input vector of an N_IN-input evolved
// logic array, compares its single output against a latched truth table and
// reports a fitness count plus a per-row mismatch map.
// DONE is high during the FINISH cycle. FITNESS/MISMATCH take the new result
// on the edge that leaves FINISH, so they are valid from the cycle after DONE.
// Optional macro CIRCUIT_OUT_SYNC_EN: routes CIRCUIT_OUT through a two-flop
// synchronizer and lengthens each DRIVE visit by two cycles to cover it.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | waiting for START; CIRCUIT_IN holds the last applied row
// S_DRIVE  | row applied to CIRCUIT_IN, settle down-counter running
// S_SAMPLE | compare CIRCUIT_OUT against the target bit, then step the row
// S_FINISH | publish score and map, DONE high for this one cycle

module truth_table_sweeper #(
  parameter int N_IN   = 4,
  parameter int SETTLE = 4
) (
  input  logic                 FPGA_CLK_50,
  input  logic                 RESET_N,
  input  logic                 START,
  input  logic [2**N_IN-1:0]   TARGET,
  output logic [N_IN-1:0]      CIRCUIT_IN,
  input  logic                 CIRCUIT_OUT,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [N_IN:0]        FITNESS,
  output logic [2**N_IN-1:0]   MISMATCH
);

  localparam int ROWS = 2**N_IN;

`ifdef CIRCUIT_OUT_SYNC_EN
  localparam int DRIVE_CYC = SETTLE + 2;

  logic sync_q1;
  logic sync_q2;
  logic circuit_out_s;

  // Two-flop synchronizer on the asynchronous array output
  always_ff @(posedge FPGA_CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= CIRCUIT_OUT;
      sync_q2 <= sync_q1;
    end
  end

  assign circuit_out_s = sync_q2;
`else
  localparam int DRIVE_CYC = SETTLE;

  logic circuit_out_s;
  assign circuit_out_s = CIRCUIT_OUT;
`endif

  localparam int CNT_W = (DRIVE_CYC > 1) ? $clog2(DRIVE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRIVE_CYC - 1);
  localparam logic [N_IN-1:0]  LAST_IDX = N_IN'(ROWS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SAMPLE = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] settle_cnt;
  logic [ROWS-1:0]  target_q;
  logic [N_IN:0]    score;
  logic [ROWS-1:0]  miss_map;
  logic             last_row;
  logic             row_match;

  assign last_row  = (CIRCUIT_IN == LAST_IDX);
  assign row_match = (circuit_out_s == target_q[CIRCUIT_IN]);

  // State register
  always_ff @(posedge FPGA_CLK_50 or negedge RESET_N) begin
    if (!RESET_N) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state decode; START only matters in IDLE so mid-sweep pulses vanish
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (START) state_nxt = S_DRIVE;
      S_DRIVE:  if (settle_cnt == '0) state_nxt = S_SAMPLE;
      S_SAMPLE: state_nxt = last_row ? S_FINISH : S_DRIVE;
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Moore outputs
  always_comb begin
    BUSY = (state != S_IDLE);
    DONE = (state == S_FINISH);
  end

  // Row index, settle timer, running score/map and published results
  always_ff @(posedge FPGA_CLK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      CIRCUIT_IN <= '0;
      settle_cnt <= '0;
      target_q   <= '0;
      score      <= '0;
      miss_map   <= '0;
      FITNESS    <= '0;
      MISMATCH   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (START) begin
            target_q   <= TARGET;
            score      <= '0;
            miss_map   <= '0;
            CIRCUIT_IN <= '0;
            settle_cnt <= CNT_LOAD;
          end
        end
        S_DRIVE: begin
          if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
        end
        S_SAMPLE: begin
          if (row_match) score <= score + 1'b1;
          else           miss_map[CIRCUIT_IN] <= 1'b1;
          // the index saturates on the last row instead of wrapping
          if (!last_row) CIRCUIT_IN <= CIRCUIT_IN + 1'b1;
          settle_cnt <= CNT_LOAD;
        end
        S_FINISH: begin
          FITNESS  <= score;
          MISMATCH <= miss_map;
        end
        default: ;
      endcase
    end
  end

endmodule
